// File: rtl/rob_pkg.sv
// Shared types and widths for the reorder buffer: entry payload, commit FSM
// state encoding and register-file index/data widths.
package rob_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      CMT_IDLE = 1'b0,
      CMT_GAP  = 1'b1
   } cmt_state_t;

   typedef struct packed {
      logic                 valid;
      logic                 ready;
      logic [REG_IDX_W-1:0] dest;
      logic [DATA_W-1:0]    data;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue/CDB channel into the reorder buffer.
//   alloc_valid/alloc_dest : issue requests an entry for destination alloc_dest
//   alloc_ready/alloc_tag  : entry available, tag granted (tail pointer index)
//   cdb_valid/tag/data     : result broadcast for entry cdb_tag
// master = issue/execute side, slave = reorder buffer.
interface reorder_buffer_if #(
   parameter int unsigned DEPTH = 8
);
   import rob_pkg::*;

   localparam int unsigned TAG_W = $clog2(DEPTH);

   logic                 alloc_valid;
   logic                 alloc_ready;
   logic [REG_IDX_W-1:0] alloc_dest;
   logic [TAG_W-1:0]     alloc_tag;
   logic                 cdb_valid;
   logic [TAG_W-1:0]     cdb_tag;
   logic [DATA_W-1:0]    cdb_data;

   modport master (
      output alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data,
      input  alloc_ready, alloc_tag
   );

   modport slave (
      input  alloc_valid, alloc_dest, cdb_valid, cdb_tag, cdb_data,
      output alloc_ready, alloc_tag
   );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer between issue and the register file.
// Allocates one tagged entry per issued instruction, captures CDB results and
// retires in program order as single-cycle write pulses to regfile.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   rob (slave)         : allocate + CDB channel (see reorder_buffer_if)
//   flush               : discard all entries (mispredict)
//   ROBwriteEnable/Index/Data : regfile write port, one-cycle pulses
//   count, empty, full  : registered occupancy
module reorder_buffer
   import rob_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned TAG_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   reorder_buffer_if.slave      rob,
   input  logic                 flush,
   output logic                 ROBwriteEnable,
   output logic [REG_IDX_W-1:0] ROBwriteIndex,
   output logic [DATA_W-1:0]    ROBwriteData,
   output logic [TAG_W:0]       count,
   output logic                 empty,
   output logic                 full
);

   localparam int unsigned PTR_W = TAG_W + 1;

   rob_entry_t           entries [DEPTH];
   logic [PTR_W-1:0]     head, tail, head_next, tail_next;
   logic [PTR_W-1:0]     count_next;
   logic                 full_next, empty_next;
   logic [TAG_W-1:0]     head_idx, tail_idx;
   rob_entry_t           head_entry;
   cmt_state_t           state, state_next;
   logic                 alloc_fire;
   logic                 retire;
   logic                 retire_pulse;
   logic                 we_next;
   logic [REG_IDX_W-1:0] idx_next;
   logic [DATA_W-1:0]    data_next;
   logic                 alloc_ready_q;

   assign head_idx      = head[TAG_W-1:0];
   assign tail_idx      = tail[TAG_W-1:0];
   assign head_entry    = entries[head_idx];
   assign rob.alloc_tag = tail_idx;
   assign rob.alloc_ready = alloc_ready_q;
   assign alloc_fire    = rob.alloc_valid && alloc_ready_q;

   // Commit FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= CMT_IDLE;
      else        state <= state_next;
   end

   // Commit FSM: next state and retire decision; flush overrides everything
   always_comb begin
      state_next   = state;
      retire       = 1'b0;
      retire_pulse = 1'b0;
      case (state)
         CMT_IDLE: begin
            if (head_entry.valid && head_entry.ready) begin
               retire = 1'b1;
               // x0 destinations free silently and stay idle
               if (head_entry.dest != REG_ZERO) begin
                  retire_pulse = 1'b1;
                  state_next   = CMT_GAP;
               end
            end
         end
         CMT_GAP: state_next = CMT_IDLE;
      endcase
      if (flush) begin
         state_next   = CMT_IDLE;
         retire       = 1'b0;
         retire_pulse = 1'b0;
      end
   end

   // Commit FSM: output decode; index/data hold between pulses
   always_comb begin
      we_next   = 1'b0;
      idx_next  = ROBwriteIndex;
      data_next = ROBwriteData;
      if (retire_pulse) begin
         we_next   = 1'b1;
         idx_next  = head_entry.dest;
         data_next = head_entry.data;
      end
   end

   // Regfile write port registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ROBwriteEnable <= 1'b0;
         ROBwriteIndex  <= '0;
         ROBwriteData   <= '0;
      end else begin
         ROBwriteEnable <= we_next;
         ROBwriteIndex  <= idx_next;
         ROBwriteData   <= data_next;
      end
   end

   // Pointer and occupancy next values
   always_comb begin
      head_next = head + PTR_W'(retire);
      tail_next = tail + PTR_W'(alloc_fire);
      if (flush) begin
         head_next = '0;
         tail_next = '0;
      end
      count_next = tail_next - head_next;
      empty_next = (head_next == tail_next);
      full_next  = (head_next[TAG_W-1:0] == tail_next[TAG_W-1:0]) &&
                   (head_next[TAG_W] != tail_next[TAG_W]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         empty         <= 1'b1;
         full          <= 1'b0;
         alloc_ready_q <= 1'b1;
      end else begin
         head          <= head_next;
         tail          <= tail_next;
         count         <= count_next;
         empty         <= empty_next;
         full          <= full_next;
         alloc_ready_q <= !full_next;
      end
   end

   // Entry storage: CDB capture, retire free, allocate (flush clears valids)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
      end else begin
         if (rob.cdb_valid && entries[rob.cdb_tag].valid &&
             !entries[rob.cdb_tag].ready) begin
            entries[rob.cdb_tag].ready <= 1'b1;
            entries[rob.cdb_tag].data  <= rob.cdb_data;
         end
         if (retire) begin
            entries[head_idx].valid <= 1'b0;
            entries[head_idx].ready <= 1'b0;
         end
         if (alloc_fire) begin
            entries[tail_idx].valid <= 1'b1;
            entries[tail_idx].ready <= 1'b0;
            entries[tail_idx].dest  <= rob.alloc_dest;
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected retirements are queued at
// allocation (program order) and checked by a negedge monitor on each pulse.
module tb_reorder_buffer;
   import rob_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TAG_W = $clog2(DEPTH);

   typedef struct {
      logic [4:0]  dest;
      logic [31:0] data;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 flush;
   logic                 ROBwriteEnable;
   logic [REG_IDX_W-1:0] ROBwriteIndex;
   logic [DATA_W-1:0]    ROBwriteData;
   logic [TAG_W:0]       count;
   logic                 empty, full;

   int          checks = 0;
   int          failures = 0;
   int          pulse_cnt = 0;
   logic        prev_we = 1'b0;
   exp_t        exp_q[$];
   logic [31:0] plan [DEPTH];
   logic [TAG_W:0] exp_tail;

   reorder_buffer_if #(.DEPTH(DEPTH)) rob_if ();

   reorder_buffer #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rob            (rob_if),
      .flush          (flush),
      .ROBwriteEnable (ROBwriteEnable),
      .ROBwriteIndex  (ROBwriteIndex),
      .ROBwriteData   (ROBwriteData),
      .count          (count),
      .empty          (empty),
      .full           (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      rob_if.alloc_valid = 1'b0;
      rob_if.alloc_dest  = '0;
      rob_if.cdb_valid   = 1'b0;
      rob_if.cdb_tag     = '0;
      rob_if.cdb_data    = '0;
      exp_q.delete();
      exp_tail = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic alloc(input logic [4:0] dest, input logic [31:0] data);
      exp_t e;
      rob_if.alloc_valid = 1'b1;
      rob_if.alloc_dest  = dest;
      chk("alloc_tag", 32'(rob_if.alloc_tag), 32'(exp_tail[TAG_W-1:0]));
      plan[exp_tail[TAG_W-1:0]] = data;
      if (dest != 5'd0) begin
         e.dest = dest;
         e.data = data;
         exp_q.push_back(e);
      end
      exp_tail = exp_tail + 1'b1;
      tick();
      rob_if.alloc_valid = 1'b0;
   endtask

   task automatic cdb(input logic [TAG_W-1:0] tag);
      rob_if.cdb_valid = 1'b1;
      rob_if.cdb_tag   = tag;
      rob_if.cdb_data  = plan[tag];
      tick();
      rob_if.cdb_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (!(empty === 1'b1 && exp_q.size() == 0) && n < 40) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 40), 32'd1);
   endtask

   // Retirement monitor: every pulse must be expected, in order, and isolated
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_we = 1'b0;
      end else begin
         if (ROBwriteEnable) begin
            pulse_cnt++;
            chk("pulse_gap", 32'(prev_we), 32'd0);
            chk("pulse_expected", 32'(ROBwriteEnable), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("pulse_index", 32'(ROBwriteIndex), 32'(e.dest));
               chk("pulse_data", ROBwriteData, e.data);
            end
         end
         prev_we = ROBwriteEnable;
      end
   end

   initial begin
      int base;
      int n;
      do_reset();

      // Reset state
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_alloc_ready", 32'(rob_if.alloc_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_we", 32'(ROBwriteEnable), 32'd0);
      chk("rst_index", 32'(ROBwriteIndex), 32'd0);
      chk("rst_data", ROBwriteData, 32'd0);

      // Single retire with exact CDB-to-pulse latency
      alloc(5'd5, 32'h0000_00AB);
      chk("sr_count", 32'(count), 32'd1);
      cdb(3'd0);
      chk("sr_we_early", 32'(ROBwriteEnable), 32'd0);
      tick();
      chk("sr_we", 32'(ROBwriteEnable), 32'd1);
      chk("sr_index", 32'(ROBwriteIndex), 32'd5);
      chk("sr_data", ROBwriteData, 32'd171);
      tick();
      chk("sr_we_drop", 32'(ROBwriteEnable), 32'd0);
      chk("sr_empty", 32'(empty), 32'd1);

      // Out-of-order completion retires in program order
      do_reset();
      alloc(5'd1, 32'd10);
      alloc(5'd2, 32'd20);
      alloc(5'd3, 32'd30);
      cdb(3'd2);
      cdb(3'd1);
      chk("ooo_no_early", 32'(ROBwriteEnable), 32'd0);
      cdb(3'd0);
      drain("ooo_drain");
      chk("ooo_count", 32'(count), 32'd0);

      // Full, blocked allocate, wrap-around reuse of tags
      do_reset();
      for (int i = 0; i < 8; i++) alloc(5'(i + 1), 32'(32'h100 + i));
      chk("full_full", 32'(full), 32'd1);
      chk("full_alloc_ready", 32'(rob_if.alloc_ready), 32'd0);
      chk("full_count", 32'(count), 32'd8);
      chk("full_empty", 32'(empty), 32'd0);
      rob_if.alloc_valid = 1'b1;
      rob_if.alloc_dest  = 5'd31;
      tick();
      rob_if.alloc_valid = 1'b0;
      chk("full_blocked_count", 32'(count), 32'd8);
      cdb(3'd0);
      cdb(3'd1);
      cdb(3'd2);
      n = 0;
      while (count !== 4'd5 && n < 20) begin
         tick();
         n++;
      end
      chk("full_retire3_timeout", 32'(n < 20), 32'd1);
      chk("full_after_full", 32'(full), 32'd0);
      chk("full_after_ready", 32'(rob_if.alloc_ready), 32'd1);
      alloc(5'd9, 32'h900);
      alloc(5'd10, 32'hA00);
      alloc(5'd11, 32'hB00);
      chk("wrap_full", 32'(full), 32'd1);
      chk("wrap_count", 32'(count), 32'd8);
      for (int t = 7; t >= 3; t--) cdb(3'(t));
      cdb(3'd2);
      cdb(3'd1);
      cdb(3'd0);
      drain("wrap_drain");

      // x0 retires silently; stale CDB to a freed tag is ignored
      do_reset();
      base = pulse_cnt;
      alloc(5'd0, 32'h55);
      alloc(5'd4, 32'h44);
      cdb(3'd0);
      cdb(3'd1);
      drain("x0_drain");
      chk("x0_pulses", 32'(pulse_cnt - base), 32'd1);
      rob_if.cdb_valid = 1'b1;
      rob_if.cdb_tag   = 3'd0;
      rob_if.cdb_data  = 32'hDEAD_BEEF;
      tick();
      rob_if.cdb_valid = 1'b0;
      repeat (4) tick();
      chk("stale_pulses", 32'(pulse_cnt - base), 32'd1);
      chk("stale_count", 32'(count), 32'd0);
      chk("stale_empty", 32'(empty), 32'd1);
      chk("stale_index", 32'(ROBwriteIndex), 32'd4);
      chk("stale_data", ROBwriteData, 32'h44);

      // Flush in the cycle a pulse starts
      do_reset();
      alloc(5'd6, 32'h60);
      alloc(5'd7, 32'h61);
      alloc(5'd8, 32'h62);
      alloc(5'd9, 32'h63);
      rob_if.cdb_valid = 1'b1;
      rob_if.cdb_tag   = 3'd0;
      rob_if.cdb_data  = plan[0];
      tick();
      rob_if.cdb_tag   = 3'd1;
      rob_if.cdb_data  = plan[1];
      tick();
      rob_if.cdb_valid = 1'b0;
      flush = 1'b1;
      chk("flush_pulse_start", 32'(ROBwriteEnable), 32'd1);
      chk("flush_pulse_index", 32'(ROBwriteIndex), 32'd6);
      tick();
      flush = 1'b0;
      chk("flush_we", 32'(ROBwriteEnable), 32'd0);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_empty", 32'(empty), 32'd1);
      chk("flush_alloc_tag", 32'(rob_if.alloc_tag), 32'd0);
      chk("flush_discarded", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      exp_tail = '0;
      base = pulse_cnt;
      repeat (5) tick();
      chk("flush_no_pulse", 32'(pulse_cnt - base), 32'd0);
      alloc(5'd12, 32'h12);
      cdb(3'd0);
      drain("flush_post_drain");

      // Asynchronous reset in the middle of a pulse
      do_reset();
      alloc(5'd3, 32'h33);
      cdb(3'd0);
      tick();
      chk("ar_we_before", 32'(ROBwriteEnable), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_we", 32'(ROBwriteEnable), 32'd0);
      chk("ar_index", 32'(ROBwriteIndex), 32'd0);
      chk("ar_data", ROBwriteData, 32'd0);
      exp_q.delete();
      exp_tail = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("ar_alloc_ready", 32'(rob_if.alloc_ready), 32'd1);
      chk("ar_empty", 32'(empty), 32'd1);
      chk("ar_count", 32'(count), 32'd0);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
